// File: rtl/multi_cycle_control_pkg.sv
// Shared encodings for the multi-cycle MIPS main control unit:
// opcodes, FSM states, datapath mux selects and opcode-class indices.
package ctrl_pkg;

    localparam int OPCODE_W  = 6;
    localparam int ENC_STATE_W = 4;

    localparam logic [OPCODE_W-1:0] OP_R    = 6'b000000;
    localparam logic [OPCODE_W-1:0] OP_LW   = 6'b100011;
    localparam logic [OPCODE_W-1:0] OP_SW   = 6'b101011;
    localparam logic [OPCODE_W-1:0] OP_BEQ  = 6'b000100;
    localparam logic [OPCODE_W-1:0] OP_BNE  = 6'b000101;
    localparam logic [OPCODE_W-1:0] OP_J    = 6'b000010;
    localparam logic [OPCODE_W-1:0] OP_ADDI = 6'b001000;

    typedef enum logic [ENC_STATE_W-1:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_R_EXEC    = 4'd7,
        S_R_WB      = 4'd8,
        S_BRANCH    = 4'd9,
        S_JUMP      = 4'd10,
        S_ADDI_EXEC = 4'd11,
        S_ADDI_WB   = 4'd12
    } state_t;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam int CLS_W    = 8;
    localparam int CLS_R    = 0;
    localparam int CLS_LW   = 1;
    localparam int CLS_SW   = 2;
    localparam int CLS_BEQ  = 3;
    localparam int CLS_BNE  = 4;
    localparam int CLS_J    = 5;
    localparam int CLS_ADDI = 6;
    localparam int CLS_ILL  = 7;

endpackage

// File: rtl/multi_cycle_control_op_class_decode.sv
// Combinational opcode classifier producing a one-hot instruction class.
module op_class_decode
    import ctrl_pkg::*;
(
    input  logic [OPCODE_W-1:0] i_op,
    output logic [CLS_W-1:0]    o_class
);

    always_comb begin
        o_class = '0;
        case (i_op)
            OP_R:    o_class[CLS_R]    = 1'b1;
            OP_LW:   o_class[CLS_LW]   = 1'b1;
            OP_SW:   o_class[CLS_SW]   = 1'b1;
            OP_BEQ:  o_class[CLS_BEQ]  = 1'b1;
            OP_BNE:  o_class[CLS_BNE]  = 1'b1;
            OP_J:    o_class[CLS_J]    = 1'b1;
            OP_ADDI: o_class[CLS_ADDI] = 1'b1;
            default: o_class[CLS_ILL]  = 1'b1;
        endcase
    end

endmodule

// File: rtl/multi_cycle_control.sv
// Multi-cycle MIPS main control FSM; outputs decode from the state register,
// with mem_ready feeding FETCH and op feeding DECODE/BRANCH.
module multi_cycle_control
    import ctrl_pkg::*;
#(
    parameter int OP_W        = 6,
    parameter int MEM_WAIT_EN = 1,
    parameter int STATE_W     = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [OP_W-1:0]    op,
    input  logic               mem_ready,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               BranchNe,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               MemToReg,
    output logic               RegDst,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ALUop,
    output logic [1:0]         PCSource,
    output logic               illegal_op,
    output logic [STATE_W-1:0] state
);

    state_t           r_state;
    logic [CLS_W-1:0] w_class;
    logic             w_ready;

    assign w_ready = (MEM_WAIT_EN == 0) ? 1'b1 : mem_ready;
    assign state   = STATE_W'(r_state);

    op_class_decode u_op_class_decode (
        .i_op    (op),
        .o_class (w_class)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:      r_state <= S_FETCH;
                S_FETCH:     r_state <= w_ready ? S_DECODE : S_FETCH;
                S_DECODE: begin
                    if (w_class[CLS_LW] || w_class[CLS_SW]) r_state <= S_MEM_ADDR;
                    else if (w_class[CLS_R])                r_state <= S_R_EXEC;
                    else if (w_class[CLS_BEQ] || w_class[CLS_BNE]) r_state <= S_BRANCH;
                    else if (w_class[CLS_J])                r_state <= S_JUMP;
                    else if (w_class[CLS_ADDI])             r_state <= S_ADDI_EXEC;
                    else                                    r_state <= S_FETCH;
                end
                // IR is not rewritten after FETCH, so op still names the load/store here
                S_MEM_ADDR: begin
                    if (w_class[CLS_SW])      r_state <= S_MEM_WRITE;
                    else if (w_class[CLS_LW]) r_state <= S_MEM_READ;
                    else                      r_state <= S_FETCH;
                end
                S_MEM_READ:  r_state <= w_ready ? S_MEM_WB : S_MEM_READ;
                S_MEM_WB:    r_state <= S_FETCH;
                S_MEM_WRITE: r_state <= w_ready ? S_FETCH : S_MEM_WRITE;
                S_R_EXEC:    r_state <= S_R_WB;
                S_R_WB:      r_state <= S_FETCH;
                S_BRANCH:    r_state <= S_FETCH;
                S_JUMP:      r_state <= S_FETCH;
                S_ADDI_EXEC: r_state <= S_ADDI_WB;
                S_ADDI_WB:   r_state <= S_FETCH;
                default:     r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        BranchNe    = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemToReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_B;
        ALUop       = ALUOP_ADD;
        PCSource    = PCSRC_ALU;
        illegal_op  = 1'b0;
        case (r_state)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = SRCB_FOUR;
                IRWrite = w_ready;
                PCWrite = w_ready;
            end
            S_DECODE: begin
                ALUSrcB    = SRCB_IMM_SH;
                illegal_op = w_class[CLS_ILL];
            end
            S_MEM_ADDR, S_ADDI_EXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            S_MEM_READ: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEM_WB: begin
                RegWrite = 1'b1;
                MemToReg = 1'b1;
            end
            S_MEM_WRITE: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_R_EXEC: begin
                ALUSrcA = 1'b1;
                ALUop   = ALUOP_FUNCT;
            end
            S_R_WB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUop       = ALUOP_SUB;
                PCWriteCond = 1'b1;
                PCSource    = PCSRC_ALUOUT;
                BranchNe    = w_class[CLS_BNE];
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = PCSRC_JUMP;
            end
            S_ADDI_WB: begin
                RegWrite = 1'b1;
            end
            default: begin
                PCWrite = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/multi_cycle_control.md
# multi_cycle_control

Multi-cycle main control unit for the MIPS CPU; successor to the single-cycle combinational `Control` decoder. A state machine sequences each instruction over 3–5 cycles. It adds BNE and ADDI, an illegal-opcode flag, and a memory wait handshake (`mem_ready`) that stalls fetch and data-memory states. It sits between the instruction register (opcode source) and the shared datapath (PC, single memory, register file, ALU muxes).

## Interface
- `OP_W`, 6, opcode width.
- `MEM_WAIT_EN`, 1, when 0 `mem_ready` is ignored and treated as 1.
- `STATE_W`, 4, width of the state encoding exported on `state`.

- `clk` input 1: rising-edge clock.
- `rst` input 1: reset is asynchronous and active-high.
- `op` input OP_W: opcode from the instruction register.
- `mem_ready` input 1: memory completes the current access this cycle.
- `PCWrite` output 1: unconditional PC load.
- `PCWriteCond` output 1: conditional PC load; the datapath gates it with Zero XOR `BranchNe`.
- `BranchNe` output 1: inverts the branch condition (BNE).
- `IorD` output 1: memory address select; 0 selects PC, 1 selects ALUOut.
- `MemRead` output 1: memory read strobe.
- `MemWrite` output 1: memory write strobe.
- `IRWrite` output 1: instruction register load.
- `MemToReg` output 1: write-back data select; 1 selects MDR.
- `RegDst` output 1: destination register select; 1 selects rd.
- `RegWrite` output 1: register file write.
- `ALUSrcA` output 1: ALU A select; 0 selects PC, 1 selects A.
- `ALUSrcB` output 2: ALU B select; 00 B, 01 const 4, 10 sign-extended imm, 11 sign-extended imm<<2.
- `ALUop` output 2: 00 add, 01 sub, 10 funct-decoded.
- `PCSource` output 2: PC source; 00 ALU result, 01 ALUOut, 10 jump target.
- `illegal_op` output 1: one-cycle pulse on an unsupported opcode.
- `state` output STATE_W: current state, for debug.

## Operation
- States: IDLE, FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, R_EXEC, R_WB, BRANCH, JUMP, ADDI_EXEC, ADDI_WB.
- Opcodes: R 000000, LW 100011, SW 101011, BEQ 000100, BNE 000101, J 000010, ADDI 001000. All others are illegal.
- Any output not listed for a state is 0.
- IDLE:
  - All outputs 0.
  - Next state is FETCH.
- FETCH:
  - MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUop=00, PCSource=00.
  - IRWrite=PCWrite=`mem_ready`.
  - Stays in FETCH while `mem_ready`=0; moves to DECODE when `mem_ready`=1.
- DECODE:
  - ALUSrcA=0, ALUSrcB=11, ALUop=00.
  - Dispatches on `op`: LW/SW→MEM_ADDR, R→R_EXEC, BEQ/BNE→BRANCH, J→JUMP, ADDI→ADDI_EXEC.
  - Illegal opcode: `illegal_op`=1 and next state is FETCH.
- MEM_ADDR:
  - ALUSrcA=1, ALUSrcB=10, ALUop=00.
  - LW→MEM_READ, SW→MEM_WRITE. `op` is stable because IR is not rewritten.
- MEM_READ:
  - MemRead=1, IorD=1.
  - Waits for `mem_ready`, then goes to MEM_WB.
- MEM_WB:
  - RegWrite=1, MemToReg=1, RegDst=0.
  - Next state is FETCH.
- MEM_WRITE:
  - MemWrite=1, IorD=1.
  - Waits for `mem_ready`, then goes to FETCH.
  - MemWrite stays high for every wait cycle.
- R_EXEC:
  - ALUSrcA=1, ALUSrcB=00, ALUop=10.
  - Next state is R_WB.
- R_WB:
  - RegWrite=1, RegDst=1, MemToReg=0.
  - Next state is FETCH.
- BRANCH:
  - ALUSrcA=1, ALUSrcB=00, ALUop=01, PCWriteCond=1, PCSource=01.
  - BranchNe=1 for BNE, 0 for BEQ.
  - Next state is FETCH.
- JUMP:
  - PCWrite=1, PCSource=10.
  - Next state is FETCH.
- ADDI_EXEC:
  - ALUSrcA=1, ALUSrcB=10, ALUop=00.
  - Next state is ADDI_WB.
- ADDI_WB:
  - RegWrite=1, RegDst=0, MemToReg=0.
  - Next state is FETCH.
- Unreachable state encodings go to IDLE on the next clock, with all outputs 0.

## Timing
- Outputs are combinational from `state`, plus `mem_ready` in FETCH and `op` in DECODE/BRANCH. The state register is the only storage.
- Reset: assertion forces `state`=IDLE immediately (asynchronous), so all outputs drop to 0 mid-cycle. The first FETCH is the second rising edge after release.
- Latency with no waits, FETCH to next FETCH:
  - R: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - BEQ/BNE: 3 cycles.
  - J: 3 cycles.
  - ADDI: 4 cycles.
  - Illegal opcode: 2 cycles.
- Each cycle with `mem_ready`=0 in FETCH, MEM_READ or MEM_WRITE adds exactly one cycle. Strobes are held across waits; IRWrite/PCWrite never pulse during a wait.
- `mem_ready` is ignored in every other state.

## Structure
- Package `ctrl_pkg` holds:
  - opcode constants;
  - state enumeration (STATE_W bits);
  - ALUop, ALUSrcB and PCSource encodings.
- Sub-module `op_class_decode`: combinational `op` → one-hot class {R, LW, SW, BEQ, BNE, J, ADDI, ILLEGAL}. It is used by both the DECODE and MEM_ADDR transitions.

## Test plan
- Reset: `rst`=1 for 3 cycles → `state`=IDLE and all outputs 0. After release: IDLE, then FETCH with MemRead=1 and ALUSrcB=01.
- LW (`op`=100011), `mem_ready`=1 throughout → exactly 5 cycles: FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB. MEM_WB has RegWrite=1 and MemToReg=1. Then FETCH.
- FETCH with `mem_ready`=0 for 2 cycles → 3 FETCH cycles with MemRead=1. IRWrite=PCWrite=0 for the first two and 1 on the third. Repeat with `MEM_WAIT_EN`=0 → single FETCH cycle.
- BEQ then BNE (`op`=000100, 000101) → BRANCH cycle with PCWriteCond=1, ALUop=01, PCSource=01; BranchNe=0 then 1. Each instruction takes 3 cycles.
- Illegal `op`=111111 → `illegal_op`=1 for exactly the DECODE cycle, then FETCH. No RegWrite or MemWrite asserted.
- SW (`op`=101011) with `rst` asserted mid-MEM_WRITE (`mem_ready`=0) → MemWrite falls the same cycle and `state`=IDLE. Next SW completes in 4 cycles.
